// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, defaults and helpers for the data memory requester
package mem_pkg;

  localparam int DW_DEF    = 16;
  localparam int AW_DEF    = 16;
  localparam int DEPTH_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// rtl/sat_counter16.sv - 16-bit saturating event counter with synchronous reset
module sat_counter16
  import mem_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        en,
  output logic [15:0] count
);

  // Count enabled events, holding at 16'hFFFF once reached
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (en) begin
      count <= sat_inc16(count);
    end
  end

endmodule

// File: rtl/data_mem_requester.sv
// rtl/data_mem_requester.sv - single-outstanding load/store initiator for the DataMemory port
module data_mem_requester
  import mem_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd,
  output logic [15:0]   ld_count,
  output logic [15:0]   st_count
);

  // One extra bit so a DEPTH of 2**AW is still representable
  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [AW-1:0] mem_a_d;
  logic [DW-1:0] mem_wd_d;
  logic          mem_we_d;
  logic [DW-1:0] rsp_data_d;
  logic          rsp_err_d;
  logic          ld_inc, st_inc;
  logic          in_range;

  assign in_range  = ({1'b0, req_addr} < LIMIT);
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);

  // State and every output-facing register; mem_we comes straight from a flop
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      mem_a    <= '0;
      mem_wd   <= '0;
      mem_we   <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      mem_a    <= mem_a_d;
      mem_wd   <= mem_wd_d;
      mem_we   <= mem_we_d;
      rsp_data <= rsp_data_d;
      rsp_err  <= rsp_err_d;
    end
  end

  // Next-state and next-register decode; memory timing is folded into ISSUE/WAIT
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    mem_a_d    = mem_a;
    mem_wd_d   = mem_wd;
    mem_we_d   = 1'b0;
    rsp_data_d = rsp_data;
    rsp_err_d  = rsp_err;
    ld_inc     = 1'b0;
    st_inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          wdata_d = req_wdata;
          if (in_range) begin
            state_d  = ST_ISSUE;
            mem_a_d  = req_addr;
            mem_wd_d = req_wdata;
            mem_we_d = req_we;
            ld_inc   = !req_we;
            st_inc   = req_we;
          end else begin
            state_d    = ST_RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d    = ST_RESP;
          rsp_data_d = wdata_q;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        state_d    = ST_RESP;
        rsp_data_d = mem_rd;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d   = ST_IDLE;
          rsp_err_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  sat_counter16 u_ld_count (
    .CLK   (CLK),
    .RST   (RST),
    .en    (ld_inc),
    .count (ld_count)
  );

  sat_counter16 u_st_count (
    .CLK   (CLK),
    .RST   (RST),
    .en    (st_inc),
    .count (st_count)
  );

endmodule
